bitrev_reorder_buf: RTL and testbench

BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

---
 rtl/bitrev_reorder_buf_if.sv | 56 +++++
 rtl/bitrev_reorder_buf.sv | 146 ++++++++++++++
 tb/tb_bitrev_reorder_buf.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitrev_reorder_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitrev_reorder_buf_if
//  Purpose  : Handshake/data bundle for bitrev_reorder_buf.
//             Input side : in_valid/in_ready with in_re/in_im (natural order).
//             Output side: out_valid/out_ready with out_re/out_im, out_idx
//                          (natural output index) and out_last.
//             slave  modport : used by the reorder buffer itself.
//             master modport : used by whatever feeds and drains the buffer.
//  Revision : 1.0 - initial release
// ============================================================================
interface bitrev_reorder_buf_if #(
    parameter int N     = 512,
    parameter int WIDTH = 13
);
    localparam int LOG2N = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [LOG2N-1:0]        out_idx;
    logic                    out_last;

    modport slave (
        input  in_valid,
        input  in_re,
        input  in_im,
        output in_ready,
        output out_valid,
        output out_re,
        output out_im,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_re,
        output in_im,
        input  in_ready,
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/bitrev_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : bitrev_reorder_buf
//  Purpose  : Ping-pong frame buffer that converts a bit-reversed FFT output
//             stream into natural order. One bank is written in arrival order
//             while the other is read at bitrev(rd_cnt); both sides run at one
//             sample per clock with no bubbles between frames.
//  Ports    : clk, rst      - single rising-edge clock, synchronous active-high
//                             reset
//             bypass        - (only with BITREV_BYPASS_EN) per-frame natural
//                             order readout, captured on the frame's first
//                             sample
//             bus (slave)   - in_valid/in_ready/in_re/in_im,
//                             out_valid/out_ready/out_re/out_im/out_idx/out_last
//  Macro    : BITREV_BYPASS_EN - adds the bypass port and per-bank mode bits.
//  Revision : 1.0 - initial release
// ============================================================================
module bitrev_reorder_buf #(
    parameter int N     = 512,
    parameter int WIDTH = 13
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BITREV_BYPASS_EN
    input  logic                bypass,
`endif
    bitrev_reorder_buf_if.slave bus
);

    localparam int               LOG2N  = $clog2(N);
    localparam logic [LOG2N-1:0] c_last = LOG2N'(N - 1);

    generate
        if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
            $error("bitrev_reorder_buf: N must be a power of two and at least 4");
        end
    endgenerate

    // Both banks live in one array; the bank select is the address MSB.
    logic [2*WIDTH-1:0] r_mem [0:2*N-1];

    logic [LOG2N-1:0]   r_wr_cnt;
    logic [LOG2N-1:0]   r_rd_cnt;
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic [1:0]         r_full;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic [LOG2N-1:0]   w_rd_rev;
    logic [LOG2N-1:0]   w_rd_addr;
    logic [2*WIDTH-1:0] w_rd_data;

    // Handshake flags come straight from registered state, so neither ready
    // nor valid depends combinationally on the other side's handshake.
    assign w_in_ready  = ~r_full[r_wr_sel];
    assign w_out_valid = r_full[r_rd_sel];
    assign w_wr_fire   = bus.in_valid & w_in_ready;
    assign w_rd_fire   = w_out_valid & bus.out_ready;

    generate
        for (genvar k = 0; k < LOG2N; k++) begin : g_bitrev
            assign w_rd_rev[k] = r_rd_cnt[LOG2N-1-k];
        end
    endgenerate

`ifdef BITREV_BYPASS_EN
    // One mode bit per bank, latched with the first sample of the frame so
    // the choice travels with the data rather than with the read side.
    logic [1:0] r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 2'b00;
        end else if (w_wr_fire && (r_wr_cnt == '0)) begin
            r_mode[r_wr_sel] <= bypass;
        end
    end

    assign w_rd_addr = r_mode[r_rd_sel] ? r_rd_cnt : w_rd_rev;
`else
    assign w_rd_addr = w_rd_rev;
`endif

    // Storage is not reset: stale contents are never exposed because the
    // full flags gate every read.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[{r_wr_sel, r_wr_cnt}] <= {bus.in_re, bus.in_im};
        end
    end

    assign w_rd_data = r_mem[{r_rd_sel, w_rd_addr}];

    // Write completion and read completion may coincide; they always address
    // different banks, so the two full-flag updates never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= 2'b00;
        end else begin
            if (w_wr_fire) begin
                if (r_wr_cnt == c_last) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                    r_wr_cnt         <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (r_rd_cnt == c_last) begin
                    r_full[r_rd_sel] <= 1'b0;
                    r_rd_sel         <= ~r_rd_sel;
                    r_rd_cnt         <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;

    // Output data is squashed to zero whenever nothing is being presented.
    always_comb begin
        bus.out_re   = '0;
        bus.out_im   = '0;
        bus.out_idx  = '0;
        bus.out_last = 1'b0;
        if (w_out_valid) begin
            bus.out_re   = w_rd_data[2*WIDTH-1:WIDTH];
            bus.out_im   = w_rd_data[WIDTH-1:0];
            bus.out_idx  = r_rd_cnt;
            bus.out_last = (r_rd_cnt == c_last);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitrev_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitrev_reorder_buf
//  Purpose  : Scoreboard bench for bitrev_reorder_buf. Two instances: N=8 for
//             ordering, backpressure, stall and reset scenarios, and N=512
//             for continuous full-rate traffic. Expected outputs are derived
//             from whole input frames (index k of the output takes input
//             bitrev(k), or k for a bypass frame).
//  Macro    : BITREV_BYPASS_EN - also exercises the bypass port.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bitrev_reorder_buf;

    localparam int W  = 13;
    localparam int N8 = 8;
    localparam int L8 = 3;
    localparam int NB = 512;
    localparam int LB = 9;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        int                  idx;
        bit                  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitrev_reorder_buf_if #(.N(N8), .WIDTH(W)) b8 ();
    bitrev_reorder_buf_if #(.N(NB), .WIDTH(W)) bb ();

`ifdef BITREV_BYPASS_EN
    logic byp8;
    logic bypb;
`endif

    bitrev_reorder_buf #(.N(N8), .WIDTH(W)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
`ifdef BITREV_BYPASS_EN
        .bypass (byp8),
`endif
        .bus    (b8)
    );

    bitrev_reorder_buf #(.N(NB), .WIDTH(W)) u_dutb (
        .clk    (clk),
        .rst    (rst),
`ifdef BITREV_BYPASS_EN
        .bypass (bypb),
`endif
        .bus    (bb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int rev(input int k, input int l);
        int r = 0;
        for (int b = 0; b < l; b++)
            if (((k >> b) & 1) != 0) r |= (1 << (l - 1 - b));
        return r;
    endfunction

    // ---------------- reference model ----------------
    exp_t                q8[$];
    exp_t                qb[$];
    logic signed [W-1:0] f8_re[$], f8_im[$];
    logic signed [W-1:0] fb_re[$], fb_im[$];
    bit                  f8_byp;

    task automatic model8_accept(input logic signed [W-1:0] re,
                                 input logic signed [W-1:0] im, input bit byp);
        exp_t e;
        int   src;
        if (f8_re.size() == 0) f8_byp = byp;
        f8_re.push_back(re);
        f8_im.push_back(im);
        if (f8_re.size() == N8) begin
            for (int k = 0; k < N8; k++) begin
                src    = f8_byp ? k : rev(k, L8);
                e.re   = f8_re[src];
                e.im   = f8_im[src];
                e.idx  = k;
                e.last = (k == N8 - 1);
                q8.push_back(e);
            end
            f8_re.delete();
            f8_im.delete();
        end
    endtask

    task automatic modelb_accept(input logic signed [W-1:0] re,
                                 input logic signed [W-1:0] im);
        exp_t e;
        int   src;
        fb_re.push_back(re);
        fb_im.push_back(im);
        if (fb_re.size() == NB) begin
            for (int k = 0; k < NB; k++) begin
                src    = rev(k, LB);
                e.re   = fb_re[src];
                e.im   = fb_im[src];
                e.idx  = k;
                e.last = (k == NB - 1);
                qb.push_back(e);
            end
            fb_re.delete();
            fb_im.delete();
        end
    endtask

    // ---------------- drivers ----------------
    int stallsb = 0;

    task automatic send8(input logic signed [W-1:0] re,
                         input logic signed [W-1:0] im, input bit byp);
        int g = 0;
        @(negedge clk);
        b8.in_valid = 1'b1;
        b8.in_re    = re;
        b8.in_im    = im;
`ifdef BITREV_BYPASS_EN
        byp8 = byp;
`endif
        #1;
        while (!b8.in_ready && g < 300) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (b8.in_ready) model8_accept(re, im, byp);
        else chk("in_ready_timeout8", b8.in_ready, 1);
    endtask

    task automatic end8();
        @(negedge clk);
        b8.in_valid = 1'b0;
    endtask

    task automatic sendb(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        int g = 0;
        @(negedge clk);
        bb.in_valid = 1'b1;
        bb.in_re    = re;
        bb.in_im    = im;
        #1;
        while (!bb.in_ready && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
            stallsb++;
        end
        if (bb.in_ready) modelb_accept(re, im);
        else chk("in_ready_timeoutb", bb.in_ready, 1);
    endtask

    task automatic drain8();
        int g = 0;
        @(negedge clk);
        b8.out_ready = 1'b1;
        while (q8.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain8_left", q8.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        b8.in_valid = 1'b0;
        bb.in_valid = 1'b0;
        q8.delete();
        qb.delete();
        f8_re.delete();
        f8_im.delete();
        fb_re.delete();
        fb_im.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [W-1:0] h_re, h_im;
    int                  h_idx;
    bit                  h_stall = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            h_stall = 1'b0;
        end else if (b8.out_valid) begin
            chk("out8_expected_avail", (q8.size() > 0), 1);
            if (q8.size() > 0) begin
                chk("out8_re",   b8.out_re,   q8[0].re);
                chk("out8_im",   b8.out_im,   q8[0].im);
                chk("out8_idx",  b8.out_idx,  q8[0].idx);
                chk("out8_last", b8.out_last, q8[0].last);
            end
            if (h_stall) begin
                chk("stall8_re",  b8.out_re,  h_re);
                chk("stall8_im",  b8.out_im,  h_im);
                chk("stall8_idx", b8.out_idx, h_idx);
            end
            h_re    = b8.out_re;
            h_im    = b8.out_im;
            h_idx   = b8.out_idx;
            h_stall = !b8.out_ready;
            if (b8.out_ready && q8.size() > 0) q8.delete(0);
        end else begin
            chk("idle8_re",   b8.out_re,   0);
            chk("idle8_im",   b8.out_im,   0);
            chk("idle8_idx",  b8.out_idx,  0);
            chk("idle8_last", b8.out_last, 0);
            h_stall = 1'b0;
        end
    end

    int nb_fire  = 0;
    int first_fb = 0;
    int last_fb  = 0;

    always @(negedge clk) begin
        #2;
        if (!rst && bb.out_valid) begin
            chk("outb_expected_avail", (qb.size() > 0), 1);
            if (qb.size() > 0) begin
                chk("outb_re",   bb.out_re,   qb[0].re);
                chk("outb_im",   bb.out_im,   qb[0].im);
                chk("outb_idx",  bb.out_idx,  qb[0].idx);
                chk("outb_last", bb.out_last, qb[0].last);
            end
            if (bb.out_ready) begin
                if (nb_fire == 0) first_fb = cyc;
                last_fb = cyc;
                nb_fire++;
                if (qb.size() > 0) qb.delete(0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    bit drv_done;

    initial begin
        rst          = 1'b1;
        b8.in_valid  = 1'b0;
        b8.in_re     = '0;
        b8.in_im     = '0;
        b8.out_ready = 1'b0;
        bb.in_valid  = 1'b0;
        bb.in_re     = '0;
        bb.in_im     = '0;
        bb.out_ready = 1'b0;
`ifdef BITREV_BYPASS_EN
        byp8 = 1'b0;
        bypb = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready8",  b8.in_ready,  1);
        chk("rst_out_valid8", b8.out_valid, 0);
        chk("rst_out_last8",  b8.out_last,  0);
        chk("rst_in_readyb",  bb.in_ready,  1);
        chk("rst_out_validb", bb.out_valid, 0);

        // Ramp frame, full-rate drain: expect 0,4,2,6,1,5,3,7
        b8.out_ready = 1'b1;
        for (int k = 0; k < N8; k++) send8(W'(k), -W'(k), 1'b0);
        chk("valid_before_8th_accept", b8.out_valid, 0);
        end8();
        #1;
        chk("valid_after_8th_accept", b8.out_valid, 1);
        chk("first_out_re", b8.out_re, 0);
        drain8();

        // Backpressure: two banks fill, third frame waits for a bank
        @(negedge clk);
        b8.out_ready = 1'b0;
        for (int i = 0; i < 2 * N8; i++) send8(W'($urandom), W'($urandom), 1'b0);
        end8();
        #1;
        chk("in_ready_after_16", b8.in_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("in_ready_held_full", b8.in_ready, 0);
        @(negedge clk);
        b8.out_ready = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        chk("in_ready_before_8th_read", b8.in_ready, 0);
        @(negedge clk);
        #1;
        chk("in_ready_after_8th_read", b8.in_ready, 1);
        for (int i = 0; i < N8; i++) send8(W'($urandom), W'($urandom), 1'b0);
        end8();
        drain8();

        // out_ready toggling every cycle
        @(negedge clk);
        b8.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < N8; k++) send8(W'(k), -W'(k), 1'b0);
                end8();
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    b8.out_ready = ~b8.out_ready;
                end
            end
        join
        drain8();

        // Reset with one full frame and 5 samples of a second
        @(negedge clk);
        b8.out_ready = 1'b0;
        for (int i = 0; i < N8 + 5; i++) send8(W'($urandom), W'($urandom), 1'b0);
        end8();
        do_reset();
        #1;
        chk("post_rst_in_ready", b8.in_ready, 1);
        @(negedge clk);
        b8.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_out_valid", b8.out_valid, 0);
        end
        for (int k = 0; k < N8; k++) send8(W'($urandom), W'($urandom), 1'b0);
        end8();
        drain8();

`ifdef BITREV_BYPASS_EN
        // Frame A natural order, frame B bit-reversed
        for (int k = 0; k < N8; k++) send8(W'(k), -W'(k), 1'b1);
        for (int k = 0; k < N8; k++) send8(W'(k), -W'(k), 1'b0);
        end8();
        drain8();
`endif

        // Random traffic with random gaps and random backpressure
        drv_done = 1'b0;
        fork
            begin
                bit fb;
                for (int f = 0; f < 6; f++) begin
`ifdef BITREV_BYPASS_EN
                    fb = 1'($urandom_range(0, 1));
`else
                    fb = 1'b0;
`endif
                    for (int k = 0; k < N8; k++) begin
                        if ($urandom_range(0, 3) == 0) end8();
                        send8(W'($urandom), W'($urandom), fb);
                    end
                end
                end8();
                drv_done = 1'b1;
            end
            begin
                int g = 0;
                while (!drv_done && g < 2000) begin
                    @(negedge clk);
                    b8.out_ready = 1'($urandom_range(0, 1));
                    g++;
                end
            end
        join
        drain8();

        // N=512 continuous traffic, three frames, out_ready held high
        @(negedge clk);
        bb.out_ready = 1'b1;
        stallsb      = 0;
        nb_fire      = 0;
        for (int i = 0; i < 3 * NB; i++) sendb(W'($urandom), W'($urandom));
        @(negedge clk);
        bb.in_valid = 1'b0;
        begin
            int g = 0;
            while (qb.size() != 0 && g < 2000) begin
                @(negedge clk);
                g++;
            end
        end
        chk("drainb_left",   qb.size(), 0);
        chk("in_stall512",   stallsb,   0);
        chk("out_count512",  nb_fire,   3 * NB);
        chk("out_span512",   last_fb - first_fb, 3 * NB - 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
